// File: rtl/polyvec_basemul_acc_fsm.sv
// ---------------------------------------------------------------------------
// polyvec_basemul_acc_fsm
//
// Controller for the NTT-domain base-multiply unit. For a job of k polynomial
// pairs it requests k loads of RAM A/B. After each load it runs one compute
// pass that reads every coefficient pair once. The first pass overwrites
// RAM C. Later passes accumulate into RAM C. Writes trail reads by a fixed
// LAT-cycle valid pipeline, which is owned here together with the read and
// write pair counters.
//
// Optional feature, selected by the macro BASEMUL_TOMONT_EN:
//   defined   -> wr_tomont flags every write of the final pass
//   undefined -> wr_tomont is tied low and the pipeline has no tomont bit
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   start        begin a job (accepted only in IDLE or DONE)
//   k_sel        polynomial count, sampled with an accepted start
//   full_in      RAM A/B load complete
//   cal_en       permission to compute (level)
//   busy         high in every state except IDLE and DONE
//   load_pulse   one-cycle request to the loader for the next pair
//   ab_we_ok     RAM A/B write window
//   clear_pulse  one cycle, clears datapath accumulator before each pass
//   rd_valid     pair read strobe; rd_idx is the pair index
//   wr_valid     RAM C write strobe; wr_idx is the pair index
//   wr_acc       0 = overwrite, 1 = accumulate into RAM C
//   wr_tomont    apply Montgomery conversion on this write
//   poly_idx     current polynomial number
//   done         level, job complete
//   err          one-cycle pulse, start rejected
// ---------------------------------------------------------------------------
module polyvec_basemul_acc_fsm #(
  parameter int DEPTH = 8,
  parameter int LAT   = 5,
  parameter int KMAX  = 4,
  parameter int KW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KW-1:0]    k_sel,
  input  logic             full_in,
  input  logic             cal_en,
  output logic             busy,
  output logic             load_pulse,
  output logic             ab_we_ok,
  output logic             clear_pulse,
  output logic             rd_valid,
  output logic [DEPTH-2:0] rd_idx,
  output logic             wr_valid,
  output logic [DEPTH-2:0] wr_idx,
  output logic             wr_acc,
  output logic             wr_tomont,
  output logic [KW-1:0]    poly_idx,
  output logic             done,
  output logic             err
);

  localparam int IW = DEPTH - 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT = 3'd2;
  localparam logic [2:0] S_ARMED     = 3'd3;
  localparam logic [2:0] S_ISSUE     = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [KW-1:0] K_MAX    = KW'(KMAX);

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] k_last_q, k_last_d;   // k-1, the index of the final pass
  logic [KW-1:0] poly_q, poly_d;
  logic [IW-1:0] rd_cnt_q, rd_cnt_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] wr_cnt_q;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;
  logic          clear_q, clear_d;
  logic          busy_q, load_q, abwe_q, done_q;
  logic          k_ok;
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] acc_q;

  always_comb begin
    state_d    = state_q;
    k_last_d   = k_last_q;
    poly_d     = poly_q;
    rd_cnt_d   = rd_cnt_q;
    rd_idx_d   = rd_idx_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    clear_d    = 1'b0;
    k_ok       = (k_sel != '0) && (k_sel <= K_MAX);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (k_ok) begin
            state_d  = S_LOAD;
            k_last_d = k_sel - K_ONE;
            poly_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD:      state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: if (full_in) state_d = S_ARMED;
      S_ARMED: begin
        if (cal_en) begin
          clear_d  = 1'b1;
          rd_cnt_d = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_valid_d = 1'b1;
        rd_idx_d   = rd_cnt_q;
        rd_cnt_d   = rd_cnt_q + IDX_ONE;
        if (rd_cnt_q == IDX_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // rd_valid_q is the pipeline's entry stage, so it counts as in flight.
        if (!rd_valid_q && (vld_q == '0)) begin
          if (poly_q == k_last_q) begin
            state_d = S_DONE;
          end else begin
            poly_d  = poly_q + K_ONE;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Level outputs are decoded from the next state so that they line up with
  // the state register while still coming straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_last_q   <= '0;
      poly_q     <= '0;
      rd_cnt_q   <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
      abwe_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_last_q   <= k_last_d;
      poly_q     <= poly_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      clear_q    <= clear_d;
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      load_q     <= (state_d == S_LOAD);
      abwe_q     <= (state_d == S_LOAD) || (state_d == S_LOAD_WAIT);
      done_q     <= (state_d == S_DONE);
    end
  end

  // Write-side pipeline: stage 0 captures the registered read strobe, so the
  // last stage is rd_valid delayed by exactly LAT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      acc_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        acc_q[i] <= acc_q[i-1];
      end
      vld_q[0] <= rd_valid_q;
      acc_q[0] <= rd_valid_q && (poly_q != '0);
      if (vld_q[LAT-1]) wr_cnt_q <= wr_cnt_q + IDX_ONE;
    end
  end

`ifdef BASEMUL_TOMONT_EN
  logic [LAT-1:0] tm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tm_q <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) tm_q[i] <= tm_q[i-1];
      tm_q[0] <= rd_valid_q && (poly_q == k_last_q);
    end
  end

  assign wr_tomont = tm_q[LAT-1];
`else
  assign wr_tomont = 1'b0;
`endif

  assign busy        = busy_q;
  assign load_pulse  = load_q;
  assign ab_we_ok    = abwe_q;
  assign clear_pulse = clear_q;
  assign rd_valid    = rd_valid_q;
  assign rd_idx      = rd_idx_q;
  assign wr_valid    = vld_q[LAT-1];
  assign wr_idx      = wr_cnt_q;
  assign wr_acc      = acc_q[LAT-1];
  assign poly_idx    = poly_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_polyvec_basemul_acc_fsm.sv
// ---------------------------------------------------------------------------
// Bench for polyvec_basemul_acc_fsm (DEPTH=8, LAT=5, KMAX=4).
// A timing model predicts the cycle of every load, clear, read, write and
// done event from the job parameters. A negedge monitor records what the DUT
// actually produced, and the two event lists are compared entry by entry.
// ---------------------------------------------------------------------------
module tb_polyvec_basemul_acc_fsm;

  localparam int NP  = 128;
  localparam int LAT = 5;

  typedef struct {
    int cyc;
    int idx;
    int f1;
    int f2;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] k_sel = 3'd0;
  logic       full_in = 1'b0;
  logic       cal_en = 1'b0;
  logic       busy, load_pulse, ab_we_ok, clear_pulse, rd_valid;
  logic [6:0] rd_idx;
  logic       wr_valid;
  logic [6:0] wr_idx;
  logic       wr_acc, wr_tomont;
  logic [2:0] poly_idx;
  logic       done, err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic done_prev = 1'b0;

  int  lp_obs[$], cp_obs[$], ab_obs[$], dn_obs[$], er_obs[$];
  int  lp_exp[$], cp_exp[$], ab_exp[$], dn_exp[$];
  ev_t rd_obs[$], wr_obs[$], rd_exp[$], wr_exp[$];

  polyvec_basemul_acc_fsm dut (
    .clk(clk), .reset(reset), .start(start), .k_sel(k_sel),
    .full_in(full_in), .cal_en(cal_en), .busy(busy),
    .load_pulse(load_pulse), .ab_we_ok(ab_we_ok), .clear_pulse(clear_pulse),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .wr_valid(wr_valid),
    .wr_idx(wr_idx), .wr_acc(wr_acc), .wr_tomont(wr_tomont),
    .poly_idx(poly_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int c, input int i, input int a, input int b);
    ev_t e;
    e.cyc = c; e.idx = i; e.f1 = a; e.f2 = b;
    return e;
  endfunction

  // Event monitor: the cycle number is the count of rising edges so far.
  always @(negedge clk) begin
    if (!reset) begin
      if (load_pulse)  lp_obs.push_back(cyc);
      if (clear_pulse) cp_obs.push_back(cyc);
      if (ab_we_ok)    ab_obs.push_back(cyc);
      if (err)         er_obs.push_back(cyc);
      if (done && !done_prev) dn_obs.push_back(cyc);
      if (rd_valid) rd_obs.push_back(mk_ev(cyc, int'(rd_idx), int'(poly_idx), 0));
      if (wr_valid) wr_obs.push_back(mk_ev(cyc, int'(wr_idx), int'(wr_acc), int'(wr_tomont)));
    end
    done_prev <= done;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic clear_logs();
    lp_obs.delete(); cp_obs.delete(); ab_obs.delete(); dn_obs.delete();
    er_obs.delete(); rd_obs.delete(); wr_obs.delete();
    lp_exp.delete(); cp_exp.delete(); ab_exp.delete(); dn_exp.delete();
    rd_exp.delete(); wr_exp.delete();
  endtask

  task automatic check_trace();
    chk("n_load", lp_obs.size(), lp_exp.size());
    foreach (lp_exp[i]) if (i < lp_obs.size()) chk("load_cyc", lp_obs[i], lp_exp[i]);
    chk("n_clear", cp_obs.size(), cp_exp.size());
    foreach (cp_exp[i]) if (i < cp_obs.size()) chk("clear_cyc", cp_obs[i], cp_exp[i]);
    chk("n_abwe", ab_obs.size(), ab_exp.size());
    foreach (ab_exp[i]) if (i < ab_obs.size()) chk("abwe_cyc", ab_obs[i], ab_exp[i]);
    chk("n_done", dn_obs.size(), dn_exp.size());
    foreach (dn_exp[i]) if (i < dn_obs.size()) chk("done_cyc", dn_obs[i], dn_exp[i]);
    chk("n_err", er_obs.size(), 0);
    chk("n_rd", rd_obs.size(), rd_exp.size());
    foreach (rd_exp[i]) if (i < rd_obs.size()) begin
      chk("rd_cyc", rd_obs[i].cyc, rd_exp[i].cyc);
      chk("rd_idx", rd_obs[i].idx, rd_exp[i].idx);
      chk("rd_poly", rd_obs[i].f1, rd_exp[i].f1);
    end
    chk("n_wr", wr_obs.size(), wr_exp.size());
    foreach (wr_exp[i]) if (i < wr_obs.size()) begin
      chk("wr_cyc", wr_obs[i].cyc, wr_exp[i].cyc);
      chk("wr_idx", wr_obs[i].idx, wr_exp[i].idx);
      chk("wr_acc", wr_obs[i].f1, wr_exp[i].f1);
      chk("wr_tomont", wr_obs[i].f2, wr_exp[i].f2);
    end
  endtask

  // One complete job. fdel: cycles from load_pulse to the full_in pulse.
  // cdel < 0: cal_en held high; otherwise cal_en stays low for cdel ARMED
  // cycles and is then raised until the pass starts. poke: pulse a valid
  // start during the first ISSUE phase, which must be ignored.
  task automatic run_job(input int k, input int fdel, input int cdel, input bit poke);
    int s, l, f, clr, w, nw, tm;
    clear_logs();
    k_sel = 3'(k);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    l = s + 1;
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    chk("start_poly", int'(poly_idx), 0);
    nw = 0;
    w = l;
    for (int p = 0; p < k; p++) begin
      lp_exp.push_back(l);
      wait_until(l + fdel);
      f = cyc;
      full_in = 1'b1;
      step();
      full_in = 1'b0;
      for (int c = l; c <= f; c++) ab_exp.push_back(c);
      if (cdel < 0) begin
        cal_en = 1'b1;
        clr = f + 2;
      end else begin
        while (cyc < f + 1 + cdel) begin
          chk("armed_rd", int'(rd_valid), 0);
          chk("armed_abwe", int'(ab_we_ok), 0);
          chk("armed_busy", int'(busy), 1);
          step();
        end
        cal_en = 1'b1;
        clr = cyc + 1;
      end
      cp_exp.push_back(clr);
`ifdef BASEMUL_TOMONT_EN
      tm = (p == k - 1) ? 1 : 0;
`else
      tm = 0;
`endif
      for (int i = 0; i < NP; i++) begin
        rd_exp.push_back(mk_ev(clr + 1 + i, i, p, 0));
        wr_exp.push_back(mk_ev(clr + 1 + i + LAT, nw % NP, (p != 0) ? 1 : 0, tm));
        nw++;
      end
      wait_until(clr);
      if (cdel >= 0) cal_en = 1'b0;
      if (poke && p == 0) begin
        wait_until(clr + 10);
        k_sel = 3'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        k_sel = 3'(k);
      end
      w = clr + NP + LAT;
      l = w + 2;
    end
    dn_exp.push_back(w + 2);
    wait_until(w + 4);
    cal_en = 1'b0;
    chk("end_done", int'(done), 1);
    chk("end_busy", int'(busy), 0);
    check_trace();
    $display("job k=%0d fdel=%0d cdel=%0d poke=%0d: %0d writes seen", k, fdel, cdel, poke, wr_obs.size());
  endtask

  // Rejected start: one err pulse, nothing else moves.
  task automatic bad_start(input int k, input int exp_done);
    int s;
    clear_logs();
    k_sel = 3'(k);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    wait_until(s + 4);
    chk("err_count", er_obs.size(), 1);
    if (er_obs.size() > 0) chk("err_cyc", er_obs[0], s + 1);
    chk("err_no_load", lp_obs.size(), 0);
    chk("err_busy", int'(busy), 0);
    chk("err_done", int'(done), exp_done);
    $display("bad start k_sel=%0d: err pulses %0d", k, er_obs.size());
  endtask

  initial begin
    int s, l, f, clr;
    step();
    step();
    chk("rst_outputs", int'({busy, load_pulse, ab_we_ok, clear_pulse, rd_valid, rd_idx,
        wr_valid, wr_idx, wr_acc, wr_tomont, poly_idx, done, err}), 0);
    reset = 1'b0;
    step();
    chk("idle_outputs", int'({busy, load_pulse, ab_we_ok, clear_pulse, rd_valid, rd_idx,
        wr_valid, wr_idx, wr_acc, wr_tomont, poly_idx, done, err}), 0);

    bad_start(0, 0);
    bad_start(5, 0);

    run_job(1, 10, -1, 1'b0);
    run_job(3, int'($urandom_range(1, 12)), int'($urandom_range(0, 6)), 1'b1);
    bad_start(0, 1);
    run_job(2, 4, 20, 1'b0);

    // Abort a job with reset while rd_idx is 60.
    clear_logs();
    k_sel = 3'd2;
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    l = s + 1;
    wait_until(l + 3);
    f = cyc;
    full_in = 1'b1;
    step();
    full_in = 1'b0;
    cal_en = 1'b1;
    clr = f + 2;
    wait_until(clr + 61);
    chk("abort_rd_valid", int'(rd_valid), 1);
    chk("abort_rd_idx", int'(rd_idx), 60);
    cal_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_outputs", int'({busy, load_pulse, ab_we_ok, clear_pulse, rd_valid, rd_idx,
        wr_valid, wr_idx, wr_acc, wr_tomont, poly_idx, done, err}), 0);
    $display("reset asserted at rd_idx 60: outputs cleared");
    step();
    step();
    reset = 1'b0;
    step();
    run_job(2, 3, -1, 1'b0);

    for (int j = 0; j < 3; j++) begin
      int kk, fd, cd;
      kk = int'($urandom_range(1, 4));
      fd = int'($urandom_range(1, 12));
      cd = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 8));
      run_job(kk, fd, cd, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
